// File: rtl/nn_pkg.sv
// nn_pkg: shared fp32 field layout and layer-3 arg-max state encoding
package nn_pkg;
    localparam int FP32_W = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int MANT_W = 23;
    localparam logic [EXP_MSB-EXP_LSB:0] FP32_EXP_ALL1 = 8'hFF;
    typedef enum logic {ACCUM, HOLD} argmax_state_t;
endpackage

// File: rtl/layer3_argmax_if.sv
// layer3_argmax_if: node-output stream in, one class/score result beat out
//   slave  (arg-max block): takes in_valid/in_data/in_last/out_ready, drives the rest
//   master (producer/consumer side): the mirror image
interface layer3_argmax_if #(parameter int IDX_W = 4);
    import nn_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [FP32_W-1:0] in_data;
    logic in_last;
    logic out_valid;
    logic out_ready;
    logic [IDX_W-1:0] out_class;
    logic [FP32_W-1:0] out_score;
    logic out_err;
    modport slave (
        input in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_class, out_score, out_err
    );
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input in_ready, out_valid, out_class, out_score, out_err
    );
endinterface

// File: rtl/fp32_relu_key.sv
// fp32_relu_key: fp32 -> 31-bit unsigned sortable key, negatives and NaN clamp to 0
//   d   in  fp32 value
//   key out magnitude bits, comparable as unsigned for non-negative fp32
module fp32_relu_key
    import nn_pkg::*;
(
    input  logic [FP32_W-1:0] d,
    output logic [EXP_MSB:0]  key
);
    logic nan;
    always_comb begin
        nan = d[EXP_MSB:EXP_LSB] == FP32_EXP_ALL1 && d[MANT_W-1:0] != '0;
        key = (d[SIGN_BIT] || nan) ? '0 : d[EXP_MSB:0];
    end
endmodule

// File: rtl/layer3_argmax.sv
// layer3_argmax: streaming arg-max over one frame of layer-3 node outputs
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of layer3_argmax_if (input stream + result beat)
module layer3_argmax
    import nn_pkg::*;
#(
    parameter int N_CLASSES = 10,
    parameter int IDX_W = 4
) (
    input logic clk,
    input logic rst,
    layer3_argmax_if.slave bus
);
    argmax_state_t state, state_nxt;
    logic [IDX_W-1:0] count, best_idx, fin_idx;
    logic [EXP_MSB:0] key, best_key, fin_key;
    logic acc, last_cnt, frame_end, take;

    fp32_relu_key u_key (.d(bus.in_data), .key(key));

    assign bus.in_ready = state == ACCUM;
    assign bus.out_valid = state == HOLD;

    // fin_* already include the current beat so frame end can register them directly
    always_comb begin
        acc = bus.in_valid && bus.in_ready;
        last_cnt = count == IDX_W'(N_CLASSES - 1);
        frame_end = acc && (bus.in_last || last_cnt);
        take = count == '0 || key > best_key;
        fin_key = take ? key : best_key;
        fin_idx = take ? count : best_idx;
        state_nxt = frame_end ? HOLD : (state == HOLD && bus.out_ready) ? ACCUM : state;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= ACCUM;
        else state <= state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            best_key <= '0;
            best_idx <= '0;
            bus.out_class <= '0;
            bus.out_score <= '0;
            bus.out_err <= 1'b0;
        end else if (acc) begin
            count <= frame_end ? '0 : count + 1'b1;
            best_key <= fin_key;
            best_idx <= fin_idx;
            if (frame_end) begin
                bus.out_class <= fin_idx;
                bus.out_score <= {1'b0, fin_key};
                bus.out_err <= bus.in_last != last_cnt;
            end
        end else if (state == HOLD && bus.out_ready) begin
            best_key <= '0;
            best_idx <= '0;
        end
    end
endmodule

// File: tb/tb_layer3_argmax.sv
// tb_layer3_argmax: directed self-checking bench for layer3_argmax
module tb_layer3_argmax;
    localparam logic [31:0] HALF = 32'h3F000000;
    localparam logic [31:0] ONE = 32'h3F800000;
    localparam logic [31:0] TWO = 32'h40000000;
    localparam logic [31:0] NEG1 = 32'hBF800000;

    logic clk = 0;
    logic rst = 1;
    int checks = 0;
    int fails = 0;
    logic [31:0] vec [10];

    layer3_argmax_if #(.IDX_W(4)) bus ();
    layer3_argmax #(.N_CLASSES(10), .IDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task send(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1;
        bus.in_data = d;
        bus.in_last = l;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n == 50) begin
            checks++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 0;
        bus.in_last = 0;
    endtask

    task send_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) send(vec[i], i == last_at);
    endtask

    task expect_result(input string name, input logic [3:0] cls, input logic [31:0] score, input logic err);
        checks++;
        if (bus.out_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_valid: got %b, required 1", name, bus.out_valid);
        end
        checks++;
        if (bus.out_class !== cls) begin
            fails++;
            $display("FAIL %s_class: got %0d, required %0d", name, bus.out_class, cls);
        end
        checks++;
        if (bus.out_score !== score) begin
            fails++;
            $display("FAIL %s_score: got %h, required %h", name, bus.out_score, score);
        end
        checks++;
        if (bus.out_err !== err) begin
            fails++;
            $display("FAIL %s_err: got %b, required %b", name, bus.out_err, err);
        end
    endtask

    task handshake(input string name);
        bus.out_ready = 1;
        @(posedge clk);
        #1;
        bus.out_ready = 0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_handshake: out_valid=%b in_ready=%b, required 0/1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task test_reset();
        @(posedge clk);
        #1;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_class, bus.out_score, bus.out_err} !== {1'b1, 1'b0, 4'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_values: rdy=%b vld=%b cls=%0d score=%h err=%b, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_class, bus.out_score, bus.out_err);
        end
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task test_basic();
        for (int i = 0; i < 10; i++) vec[i] = ONE;
        vec[0] = HALF;
        vec[6] = TWO;
        send_frame(10, 9);
        expect_result("basic", 4'd6, TWO, 1'b0);
        handshake("basic");
        checks++;
        if (bus.out_class !== 4'd6 || bus.out_score !== TWO) begin
            fails++;
            $display("FAIL basic_hold_after: cls=%0d score=%h, required 6 %h", bus.out_class, bus.out_score, TWO);
        end
    endtask

    task test_tie();
        for (int i = 0; i < 10; i++) vec[i] = NEG1;
        vec[3] = ONE;
        vec[7] = ONE;
        send_frame(10, 9);
        expect_result("tie", 4'd3, ONE, 1'b0);
        handshake("tie");
    endtask

    task test_negatives();
        for (int i = 0; i < 10; i++) vec[i] = NEG1 + 32'(i);
        vec[4] = 32'h80000000;
        send_frame(10, 9);
        expect_result("neg", 4'd0, 32'd0, 1'b0);
        handshake("neg");
    endtask

    task test_back_to_back();
        for (int i = 0; i < 10; i++) vec[i] = ONE;
        vec[5] = TWO;
        send_frame(10, 9);
        expect_result("bp_first", 4'd5, TWO, 1'b0);
        for (int i = 0; i < 10; i++) vec[i] = HALF;
        vec[0] = TWO;
        bus.in_valid = 1;
        bus.in_data = vec[0];
        bus.in_last = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_class !== 4'd5) begin
                fails++;
                $display("FAIL bp_stall_%0d: rdy=%b vld=%b cls=%0d, required 0 1 5", c, bus.in_ready, bus.out_valid, bus.out_class);
            end
        end
        handshake("bp");
        send_frame(10, 9);
        expect_result("bp_second", 4'd0, TWO, 1'b0);
        handshake("bp_second");
    endtask

    task test_len_early();
        for (int i = 0; i < 10; i++) vec[i] = ONE;
        vec[2] = TWO;
        vec[7] = 32'h41000000;
        send_frame(5, 4);
        expect_result("early_last", 4'd2, TWO, 1'b1);
        handshake("early_last");
    endtask

    task test_len_nolast();
        for (int i = 0; i < 10; i++) vec[i] = HALF;
        vec[9] = ONE;
        send_frame(10, -1);
        expect_result("no_last", 4'd9, ONE, 1'b1);
        handshake("no_last");
    endtask

    task test_nan_inf();
        for (int i = 0; i < 10; i++) vec[i] = ONE;
        vec[2] = 32'h7FC00000;
        vec[8] = 32'h7F800000;
        send_frame(10, 9);
        expect_result("nan_inf", 4'd8, 32'h7F800000, 1'b0);
        handshake("nan_inf");
    endtask

    task test_reset_midframe();
        for (int i = 0; i < 10; i++) vec[i] = ONE;
        vec[5] = TWO;
        send_frame(6, -1);
        rst = 1;
        #2;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_class, bus.out_score, bus.out_err} !== {1'b1, 1'b0, 4'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL midreset_values: rdy=%b vld=%b cls=%0d score=%h err=%b, required 1 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_class, bus.out_score, bus.out_err);
        end
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 10; i++) vec[i] = HALF;
        vec[1] = ONE;
        send_frame(10, 9);
        expect_result("midreset_clean", 4'd1, ONE, 1'b0);
        handshake("midreset_clean");
    endtask

    initial begin
        bus.in_valid = 0;
        bus.in_data = 0;
        bus.in_last = 0;
        bus.out_ready = 0;
        test_reset();
        test_basic();
        test_tie();
        test_negatives();
        test_back_to_back();
        test_len_early();
        test_len_nolast();
        test_nan_inf();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/layer3_argmax.md
# layer3_argmax

Streaming arg-max classifier that sits directly downstream of the layer-3 neuron nodes. It accepts the ReLU-clamped IEEE-754 single-precision node outputs one per beat over a valid/ready handshake. It tracks the running maximum and its index, and presents the winning class index and score as one result beat per frame. It converts the layer-3 activation vector into the final ECG class decision.

## Interface
Parameters:
- N_CLASSES, 10, number of node outputs per frame (2..16)
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= N_CLASSES

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- in_valid  in  1  in_data/in_last carry a beat
- in_ready  out  1  block accepts a beat this cycle
- in_data  in  32  fp32 node output, element k of the frame
- in_last  in  1  marks the final element of a frame
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts the result
- out_class  out  IDX_W  index of the maximum element
- out_score  out  32  fp32 value of the maximum, after key clamping
- out_err  out  1  frame length differed from N_CLASSES

## Operation
- States: ACCUM and HOLD. Reset enters ACCUM.
- Reset values: in_ready=1, out_valid=0, out_class=0, out_score=0, out_err=0.
- Internal reset values: count=0, best_key=0, best_idx=0.
- Beat acceptance:
  - A beat is accepted when in_valid && in_ready.
  - in_ready=1 only in ACCUM.
- Key computation for each accepted beat:
  - If sign=1, key=0. This covers -0 and negatives.
  - If NaN (exp=0xFF, mantissa!=0), key=0.
  - Otherwise key=in_data[30:0].
  - Keys are compared as 31-bit unsigned; this is valid because all keys are non-negative fp32. +Inf is a legal maximum.
- Update rule:
  - Beat 0 of a frame (count==0) loads best_key and best_idx unconditionally.
  - Later beats replace the best only if key > best_key, strictly. Ties keep the lower index.
- Frame end: the frame ends on the accepted beat with in_last=1, or on the beat where count==N_CLASSES-1, whichever comes first.
- At frame end:
  - Register out_class=final best_idx and out_score={1'b0,final best_key}. The "final" values include the current beat.
  - Set out_err=1 if in_last and count==N_CLASSES-1 do not coincide. This covers early last, and no last on the Nth beat.
  - Clear count and go to HOLD.
- HOLD:
  - out_valid=1 and outputs stay stable.
  - When out_valid && out_ready: clear out_valid, return to ACCUM, and clear best_key/best_idx.
- Beats arriving while in HOLD are back-pressured and never dropped.
- Asserting rst mid-frame or in HOLD discards all partial or pending state and returns immediately to reset values.

## Timing
- in_ready is a registered state decode; no combinational path from out_ready to in_ready.
- Result latency: out_valid rises on the clock edge that accepts the frame-end beat, so it is visible the cycle after that beat is presented.
- Minimum frame period is N_CLASSES+1 cycles: N accept cycles plus one HOLD cycle with out_ready=1. There is no same-cycle HOLD→accept bypass.
- out_class, out_score and out_err change only on frame-end edges. They hold their value after the handshake until the next frame ends.
- in_valid may drop mid-frame (bubbles). count advances only on accepted beats.

## Structure
- Shared package nn_pkg holds:
  - FP32_W=32
  - field positions: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MANT_W=23
  - FP32_EXP_ALL1=8'hFF
- One combinational sub-module, fp32_relu_key, maps 32-bit fp32 to the 31-bit sortable key (sign/NaN clamp). It is reusable by later max-pool stages.
- State, count, best registers and the handshake logic live in layer3_argmax.

## Test plan
- Basic frame:
  - Stimulus: N=10; frame 0x3F000000(0.5) at index 0, 0x40000000(2.0) at index 6, 0x3F800000(1.0) elsewhere; in_last on beat 9.
  - Required: out_class=6, out_score=0x40000000, out_err=0, out_valid one cycle after beat 9.
- Tie and negatives:
  - Stimulus: all ten beats 0xBF800000(-1.0), except 0x3F800000 at indices 3 and 7.
  - Required: out_class=3, score 0x3F800000.
  - Stimulus: all ten beats negative.
  - Required: out_class=0, out_score=0.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles after the result; next frame presented immediately.
  - Required: in_ready=0 throughout, no beats lost, second result correct after the handshake.
- Length errors:
  - Stimulus: in_last on beat 4.
  - Required: frame ends, out_err=1, class chosen from beats 0-4.
  - Stimulus: 10 beats with no in_last.
  - Required: frame ends at beat 9 with out_err=1.
- NaN/Inf:
  - Stimulus: 0x7FC00000 at index 2, 0x7F800000 at index 8, 1.0 elsewhere.
  - Required: out_class=8, out_score=0x7F800000.
- Reset mid-frame:
  - Stimulus: assert rst after beat 5 (index 5 = 2.0), then a clean frame of all 0.5 plus 1.0 at index 1.
  - Required: outputs return to reset values; the result is class 1 with no carry-over.
